// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. One GROUP-bit lookahead group
// is resolved per stage, behind an operand register, under valid/ready flow control.
module cla_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTAGE = WIDTH / GROUP;

  // Flattened sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]ci
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                               input logic [GROUP-1:0] g,
                                               input logic             ci);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP); i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             stall;
  logic [NSTAGE:0]  v_q;
  logic [WIDTH-1:0] x_q   [NSTAGE];
  logic [WIDTH-1:0] ye_q  [NSTAGE];
  logic [WIDTH-1:0] sum_q [1:NSTAGE];
  logic             c_q   [NSTAGE+1];
  logic             ovf_q;

  assign out_valid = v_q[NSTAGE];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign s         = sum_q[NSTAGE];
  assign cout      = c_q[NSTAGE];
  assign ovf       = ovf_q;

  // Occupancy marks; bubbles shift through exactly like beats
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (!stall) begin
      v_q <= {v_q[NSTAGE-1:0], in_valid};
    end
  end

  // Operand register: subtraction folds into inverted y plus forced carry-in
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q[0]  <= '0;
      ye_q[0] <= '0;
      c_q[0]  <= 1'b0;
    end else if (!stall) begin
      x_q[0]  <= x;
      ye_q[0] <= sub ? ~y : y;
      c_q[0]  <= sub | cin;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned LSB = k * GROUP;

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic [WIDTH-1:0] lower;

    assign p = x_q[k][LSB +: GROUP] ^ ye_q[k][LSB +: GROUP];
    assign g = x_q[k][LSB +: GROUP] & ye_q[k][LSB +: GROUP];
    assign c = lookahead(p, g, c_q[k]);

    if (k == 0) begin : g_first
      assign lower = '0;
    end else begin : g_rest
      assign lower = sum_q[k];
    end

    // Lower-group sum bits ride along; this stage fills in its own group
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q[k+1] <= '0;
        c_q[k+1]   <= 1'b0;
      end else if (!stall) begin
        sum_q[k+1]                 <= lower;
        sum_q[k+1][LSB +: GROUP]   <= p ^ c[GROUP-1:0];
        c_q[k+1]                   <= c[GROUP];
      end
    end

    if (k + 1 < NSTAGE) begin : g_fwd
      always_ff @(posedge clk) begin
        if (rst) begin
          x_q[k+1]  <= '0;
          ye_q[k+1] <= '0;
        end else if (!stall) begin
          x_q[k+1]  <= x_q[k];
          ye_q[k+1] <= ye_q[k];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= c[GROUP-1] ^ c[GROUP];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// Scoreboard bench for cla_pipe: a 12/4 instance with directed vectors and a
// 16/8 instance with a directed vector plus a model-checked random sweep.
module tb_cla_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_sub, a_cin, a_out_valid, a_out_ready, a_cout, a_ovf;
  logic [11:0] a_x, a_y, a_s;
  logic        b_in_valid, b_in_ready, b_sub, b_cin, b_out_valid, b_out_ready, b_cout, b_ovf;
  logic [15:0] b_x, b_y, b_s;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_done;

  cla_pipe #(.WIDTH(12), .GROUP(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sub(a_sub), .cin(a_cin), .x(a_x), .y(a_y), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .s(a_s), .cout(a_cout), .ovf(a_ovf)
  );

  cla_pipe #(.WIDTH(16), .GROUP(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sub(b_sub), .cin(b_cin), .x(b_x), .y(b_y), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .s(b_s), .cout(b_cout), .ovf(b_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y,
                                   input logic sub, input logic cin);
    logic [16:0] t;
    logic [15:0] ye;
    exp_t        e;
    ye     = sub ? ~y : y;
    t      = {1'b0, x} + {1'b0, ye} + 17'(sub | cin);
    e.s    = t[15:0];
    e.cout = t[16];
    e.ovf  = (x[15] == ye[15]) && (t[15] != x[15]);
    return e;
  endfunction

  // Monitors: compare each result as it is consumed
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_extra: got unexpected result %0h expected none", a_s);
      end else begin
        ea = qa.pop_front();
        check("a_s", 32'(a_s), 32'(ea.s[11:0]));
        check("a_cout", 32'(a_cout), 32'(ea.cout));
        check("a_ovf", 32'(a_ovf), 32'(ea.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_extra: got unexpected result %0h expected none", b_s);
      end else begin
        eb = qb.pop_front();
        check("b_s", 32'(b_s), 32'(eb.s));
        check("b_cout", 32'(b_cout), 32'(eb.cout));
        check("b_ovf", 32'(b_ovf), 32'(eb.ovf));
      end
    end
  end

  task automatic send_a(input logic [11:0] x, input logic [11:0] y,
                        input logic sub, input logic cin, input exp_t e);
    int guard = 0;
    a_in_valid = 1'b1; a_x = x; a_y = y; a_sub = sub; a_cin = cin;
    @(negedge clk);
    while (!a_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!a_in_ready) begin
      a_in_valid = 1'b0;
      n_vec++; n_err++;
      $display("FAIL a_accept: got in_ready=0 expected 1 within 50 cycles");
      return;
    end
    qa.push_back(e);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] x, input logic [15:0] y,
                        input logic sub, input logic cin, input exp_t e);
    int guard = 0;
    b_in_valid = 1'b1; b_x = x; b_y = y; b_sub = sub; b_cin = cin;
    @(negedge clk);
    while (!b_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!b_in_ready) begin
      b_in_valid = 1'b0;
      n_vec++; n_err++;
      $display("FAIL b_accept: got in_ready=0 expected 1 within 50 cycles");
      return;
    end
    qb.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_a_valid(input string name);
    int guard = 0;
    while (!a_out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check(name, 32'(a_out_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_sub = 0; a_cin = 0; a_x = '0; a_y = '0; a_out_ready = 1;
    b_in_valid = 0; b_sub = 0; b_cin = 0; b_x = '0; b_y = '0; b_out_ready = 1;
    rnd_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_s", 32'(a_s), 32'd0);
    check("rst_cout", 32'(a_cout), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;

    // Wrap-around add with latency of three edges
    send_a(12'hFFF, 12'h001, 1'b0, 1'b0, mk(16'h000, 1'b1, 1'b0));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("a_latency", 32'(a_out_valid), 32'(i == 3));
    end
    idle(2);

    // Subtraction (cin ignored), signed overflow, back-to-back mix
    send_a(12'h005, 12'h007, 1'b1, 1'b1, mk(16'hFFE, 1'b0, 1'b0));
    send_a(12'h007, 12'h005, 1'b1, 1'b0, mk(16'h002, 1'b1, 1'b0));
    send_a(12'h7FF, 12'h001, 1'b0, 1'b0, mk(16'h800, 1'b0, 1'b1));
    send_a(12'h800, 12'h001, 1'b1, 1'b0, mk(16'h7FF, 1'b1, 1'b1));
    send_a(12'h123, 12'h456, 1'b0, 1'b1, mk(16'h57A, 1'b0, 1'b0));
    send_a(12'hABC, 12'hDEF, 1'b0, 1'b0, mk(16'h8AB, 1'b1, 1'b0));
    idle(6);

    // Backpressure: stall two cycles once the first of five results appears
    fork
      begin
        for (int i = 0; i < 5; i++)
          send_a(12'(i), 12'h100, 1'b0, 1'b0, mk(16'(12'h100 + 12'(i)), 1'b0, 1'b0));
      end
      begin
        wait_a_valid("bp_first_valid");
        a_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(a_in_ready), 32'd0);
          check("bp_hold_valid", 32'(a_out_valid), 32'd1);
          check("bp_hold_s", 32'(a_s), 32'h100);
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
      end
    join
    idle(8);

    // Reset with two beats in flight
    send_a(12'h111, 12'h222, 1'b0, 1'b0, mk(16'h333, 1'b0, 1'b0));
    send_a(12'h444, 12'h555, 1'b0, 1'b0, mk(16'h999, 1'b0, 1'b0));
    rst = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rf_out_valid", 32'(a_out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send_a(12'h0F0, 12'h00F, 1'b0, 1'b0, mk(16'h0FF, 1'b0, 1'b0));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("rf_latency", 32'(a_out_valid), 32'(i == 3));
    end
    idle(2);

    // Reset while a result is held under backpressure
    a_out_ready = 1'b0;
    send_a(12'h010, 12'h020, 1'b0, 1'b0, mk(16'h030, 1'b0, 1'b0));
    wait_a_valid("rs_held_valid");
    rst = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rs_out_valid", 32'(a_out_valid), 32'd0);
    check("rs_in_ready", 32'(a_in_ready), 32'd1);
    a_out_ready = 1'b1;
    idle(2);

    // 16/8 instance: directed overflow then random sweep with random backpressure
    send_b(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1));
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      check("b_latency", 32'(b_out_valid), 32'(i == 2));
    end
    idle(2);
    fork
      begin
        logic [15:0] rx, ry;
        logic        rs, rc;
        for (int i = 0; i < 1000; i++) begin
          rx = 16'($urandom); ry = 16'($urandom);
          rs = 1'($urandom); rc = 1'($urandom);
          send_b(rx, ry, rs, rc, model16(rx, ry, rs, rc));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          b_out_ready = ($urandom_range(0, 3) != 0);
        end
        b_out_ready = 1'b1;
      end
    join

    // Drain both scoreboards
    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
